// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit alu: accepts one op,
// holds operands for EXEC_CYCLES settle cycles, captures result/status, returns it.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_sel0,
    input  logic [3:0]  req_sel1,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_y,
    output logic [4:0]  rsp_status,
    output logic [3:0]  alu_sel,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic [4:0]  alu_status,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(EXEC_CYCLES - 1);

    state_t     state;
    logic       last;
    logic [2:0] cnt;
    logic       winner;
    logic       accept;

    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

    // Ready is offered only to the winner, so at most one bit can ever be set.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && req_valid != 2'b00)
            req_ready[winner] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    // The operand registers are the alu_* outputs themselves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            cnt        <= '0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_y      <= '0;
            rsp_status <= '0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_sel  <= winner ? req_sel1 : req_sel0;
                        alu_a    <= winner ? req_a1   : req_a0;
                        alu_b    <= winner ? req_b1   : req_b0;
                        grant_id <= winner;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_CNT) begin
                        rsp_y      <= alu_y;
                        rsp_status <= alu_status;
                        rsp_valid  <= grant_id ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        last      <= grant_id;
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three instances (EXEC_CYCLES 1, 4, 7) share stimulus,
// each driving its own combinational alu model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  rsp_ready = '0;
    logic [3:0]  req_sel0 = '0, req_sel1 = '0;
    logic [15:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;

    logic [1:0]  rr1, rv1, rr4, rv4, rr7, rv7;
    logic [15:0] y1, y4, y7, aa1, aa4, aa7, ab1, ab4, ab7, ay1, ay4, ay7;
    logic [4:0]  st1, st4, st7, ast1, ast4, ast7;
    logic [3:0]  as1, as4, as7;
    logic        busy1, busy4, busy7, gid1, gid4, gid7;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // status = {carry/borrow, overflow, negative, zero, parity}
    function automatic logic [20:0] alu_model(input logic [3:0] s, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] r;
        logic v;
        v = 1'b0;
        case (s)
            4'h0: begin
                r = {1'b0, a} + {1'b0, b};
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h1: begin
                r = {1'b0, a} - {1'b0, b};
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'h2:    r = {1'b0, a & b};
            4'h3:    r = {1'b0, a | b};
            4'h4:    r = {1'b0, a ^ b};
            default: r = {1'b0, a};
        endcase
        return {r[16], v, r[15], (r[15:0] == 16'h0), ^r[15:0], r[15:0]};
    endfunction

    assign {ast1, ay1} = alu_model(as1, aa1, ab1);
    assign {ast4, ay4} = alu_model(as4, aa4, ab4);
    assign {ast7, ay7} = alu_model(as7, aa7, ab7);

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1),
        .req_sel0(req_sel0), .req_sel1(req_sel1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_y(y1), .rsp_status(st1), .alu_sel(as1), .alu_a(aa1), .alu_b(ab1),
        .alu_y(ay1), .alu_status(ast1), .busy(busy1), .grant_id(gid1));

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr4),
        .req_sel0(req_sel0), .req_sel1(req_sel1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rv4), .rsp_ready(rsp_ready),
        .rsp_y(y4), .rsp_status(st4), .alu_sel(as4), .alu_a(aa4), .alu_b(ab4),
        .alu_y(ay4), .alu_status(ast4), .busy(busy4), .grant_id(gid4));

    alu_arbiter #(.EXEC_CYCLES(7)) dut7 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr7),
        .req_sel0(req_sel0), .req_sel1(req_sel1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rv7), .rsp_ready(rsp_ready),
        .rsp_y(y7), .rsp_status(st7), .alu_sel(as7), .alu_a(aa7), .alu_b(ab7),
        .alu_y(ay7), .alu_status(ast7), .busy(busy7), .grant_id(gid7));

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [4:0]  st;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set0(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        req_sel0 = s; req_a0 = a; req_b0 = b;
    endtask

    task automatic set1(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        req_sel1 = s; req_a1 = a; req_b1 = b;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rv1), 'h0);
        chk({tag, "_busy"}, 32'(busy1), 'h0);
        chk({tag, "_grant_id"}, 32'(gid1), 'h0);
        chk({tag, "_alu_sel"}, 32'(as1), 'h0);
        chk({tag, "_alu_a"}, 32'(aa1), 'h0);
        chk({tag, "_alu_b"}, 32'(ab1), 'h0);
        chk({tag, "_rsp_y"}, 32'(y1), 'h0);
        chk({tag, "_rsp_status"}, 32'(st1), 'h0);
    endtask

    initial begin
        vecs[0] = '{4'h0, 16'h1234, 16'h0F0F, 16'h2143, 5'b00001};
        vecs[1] = '{4'h1, 16'h0005, 16'h0007, 16'hFFFE, 5'b10101};
        vecs[2] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010};
        vecs[3] = '{4'h2, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000};
        vecs[4] = '{4'h3, 16'h8000, 16'h0001, 16'h8001, 5'b00100};
        vecs[5] = '{4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00010};
        vecs[6] = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01101};
        vecs[7] = '{4'hF, 16'h1357, 16'h9999, 16'h1357, 5'b00000};

        // Reset: ready must stay low while rst is high even with both requests up
        req_valid = 2'b11;
        tick();
        chk("rst_req_ready", 32'(rr1), 'h0);
        tick();
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk_reset_vals("reset");
        chk("reset_req_ready", 32'(rr1), 'h0);

        // Table: one op per vector, alternating requester, rsp_ready high
        rsp_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            logic r;
            r = 1'(i % 2);
            if (r) begin
                set1(vecs[i].sel, vecs[i].a, vecs[i].b);
                set0(4'h4, 16'hDEAD, 16'hBEEF);
                req_valid = 2'b10;
            end else begin
                set0(vecs[i].sel, vecs[i].a, vecs[i].b);
                set1(4'h4, 16'hDEAD, 16'hBEEF);
                req_valid = 2'b01;
            end
            #1;
            chk("vec_req_ready", 32'(rr1), r ? 'h2 : 'h1);
            chk("vec_idle_rsp_valid", 32'(rv1), 'h0);
            tick();
            req_valid = '0;
            chk("vec_alu_sel", 32'(as1), 32'(vecs[i].sel));
            chk("vec_alu_a", 32'(aa1), 32'(vecs[i].a));
            chk("vec_alu_b", 32'(ab1), 32'(vecs[i].b));
            chk("vec_grant_id", 32'(gid1), 32'(r));
            chk("vec_busy", 32'(busy1), 'h1);
            chk("vec_exec_rsp_valid", 32'(rv1), 'h0);
            tick();
            chk("vec_rsp_valid", 32'(rv1), r ? 'h2 : 'h1);
            chk("vec_rsp_y", 32'(y1), 32'(vecs[i].y));
            chk("vec_rsp_status", 32'(st1), 32'(vecs[i].st));
            chk("vec_resp_req_ready", 32'(rr1), 'h0);
            tick();
            chk("vec_back_idle_busy", 32'(busy1), 'h0);
            chk("vec_back_idle_rsp_valid", 32'(rv1), 'h0);
        end

        // Contention: both valid, grants alternate, acceptances 3 cycles apart
        do_reset();
        set0(4'h0, 16'h1000, 16'h0000);
        set1(4'h0, 16'h2000, 16'h0000);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            logic e;
            e = 1'(op % 2);
            #1;
            chk("cont_req_ready", 32'(rr1), e ? 'h2 : 'h1);
            tick();
            chk("cont_grant_id", 32'(gid1), 32'(e));
            chk("cont_exec_req_ready", 32'(rr1), 'h0);
            tick();
            chk("cont_rsp_valid", 32'(rv1), e ? 'h2 : 'h1);
            chk("cont_rsp_y", 32'(y1), e ? 'h2000 : 'h1000);
            chk("cont_resp_req_ready", 32'(rr1), 'h0);
            tick();
        end
        req_valid = '0;

        // Backpressure on requester 1; requester 0 waits
        do_reset();
        set1(4'h0, 16'hFFFF, 16'h0001);
        set0(4'h0, 16'h0042, 16'h0000);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1;
        chk("bp_req_ready", 32'(rr1), 'h2);
        tick();
        req_valid = 2'b11;
        #1;
        chk("bp_exec_req_ready", 32'(rr1), 'h0);
        tick();
        chk("bp_rsp_valid", 32'(rv1), 'h2);
        chk("bp_rsp_y", 32'(y1), 'h0000);
        chk("bp_rsp_status", 32'(st1), 'h12);
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) rsp_ready = 2'b01;
            #1;
            chk("bp_hold_rsp_valid", 32'(rv1), 'h2);
            chk("bp_hold_rsp_y", 32'(y1), 'h0000);
            chk("bp_hold_req_ready", 32'(rr1), 'h0);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        chk("bp_release_rsp_valid", 32'(rv1), 'h2);
        tick();
        chk("bp_done_rsp_valid", 32'(rv1), 'h0);
        chk("bp_waiter_req_ready", 32'(rr1), 'h1);
        rsp_ready = 2'b11;
        tick();
        req_valid = '0;
        tick();
        chk("bp_waiter_rsp_valid", 32'(rv1), 'h1);
        chk("bp_waiter_rsp_y", 32'(y1), 'h0042);
        tick();

        // Longer settle: EXEC_CYCLES 4 and 7 side by side
        do_reset();
        set0(4'h0, 16'h0101, 16'h0202);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        #1;
        chk("lat_pre_alu_a4", 32'(aa4), 'h0);
        chk("lat_pre_alu_a7", 32'(aa7), 'h0);
        tick();
        req_valid = '0;
        for (int k = 0; k <= 9; k++) begin
            chk("lat_rsp_valid4", 32'(rv4), (k == 4) ? 'h1 : 'h0);
            chk("lat_rsp_valid7", 32'(rv7), (k == 7) ? 'h1 : 'h0);
            chk("lat_alu_a4", 32'(aa4), 'h0101);
            chk("lat_alu_a7", 32'(aa7), 'h0101);
            if (k == 4) chk("lat_rsp_y4", 32'(y4), 'h0303);
            if (k == 7) chk("lat_rsp_y7", 32'(y7), 'h0303);
            req_a0 = ~req_a0;
            tick();
        end
        chk("lat_idle_busy4", 32'(busy4), 'h0);
        chk("lat_idle_busy7", 32'(busy7), 'h0);

        // Reset in EXEC, then reset in RESP
        do_reset();
        set1(4'h0, 16'h0ABC, 16'h0000);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        chk("rexec_busy_before", 32'(busy1), 'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rexec");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_no_rsp", 32'(rv1), 'h0);
        end
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        tick();
        chk("rresp_rsp_valid_before", 32'(rv1), 'h2);
        chk("rresp_rsp_y_before", 32'(y1), 'h0ABC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rresp");
        tick();
        chk("rresp_no_rsp", 32'(rv1), 'h0);
        req_valid = 2'b11;
        #1;
        chk("rst_next_contest", 32'(rr1), 'h1);
        rsp_ready = 2'b11;
        tick();
        req_valid = '0;
        tick();
        tick();

        // Dropped request: requester 1 loses the contest, then withdraws
        do_reset();
        set0(4'h2, 16'hFFFF, 16'h00FF);
        set1(4'h0, 16'h5555, 16'h1111);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        chk("drop_req_ready", 32'(rr1), 'h1);
        tick();
        req_valid = '0;
        tick();
        chk("drop_rsp_valid", 32'(rv1), 'h1);
        chk("drop_rsp_y", 32'(y1), 'h00FF);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("drop_idle_busy", 32'(busy1), 'h0);
            chk("drop_idle_req_ready", 32'(rr1), 'h0);
            chk("drop_idle_rsp_valid", 32'(rv1), 'h0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
